// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and defaults for the IF/MEM memory port arbiter.
//   arb_state_t    : sequencer state (IDLE / REQ / WAIT)
//   owner_t        : which requester owns the outstanding transaction
//   STARVE_MAX_DEF : default number of consecutive lost IF arbitrations
//                    before IF is forced ahead of MEM
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr
//   Saturating counter of consecutive IF arbitration losses.
//   Ports:
//     clk    in  clock
//     rst    in  asynchronous active-low reset (count -> 0)
//     clr    in  clear count (wins over inc)
//     inc    in  increment, saturating at MAX
//     at_max out count equals MAX
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != W'(MAX))) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign at_max = (cnt_reg == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one multi-cycle 64-bit memory port between the fetch stage (IF)
//   and the memory stage (MEM). One transaction outstanding at most;
//   MEM wins arbitration unless IF starvation protection forces IF ahead.
//
//   Optional feature macro: MEM_PORT_ARB_STARVE_EN
//     defined   -> after STARVE_MAX consecutive MEM grants that IF lost,
//                  the next arbitration goes to IF
//     undefined -> strict MEM priority, no counter
//
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     if_valid/if_addr         IF read request (held until if_ready)
//     if_ready                 IF request accepted (1-cycle pulse)
//     if_flush                 drop response of the accepted IF transaction
//     if_rvalid/if_rdata       IF response: 32-bit word selected by addr[2]
//     mem_valid/mem_addr/mem_we/mem_wdata   MEM load/store request
//     mem_ready                MEM request accepted (1-cycle pulse)
//     mem_rvalid/mem_rdata     MEM response (load data or store ack)
//     m_req_valid/m_req_ready  memory request handshake
//     m_addr/m_we/m_wdata      registered request fields
//     m_resp_valid/m_rdata     memory response
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_resp_valid,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_t        state_reg, state_next;
  owner_t            owner_reg, owner_next;
  logic              drop_reg, drop_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              we_reg, we_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              req_valid_reg, req_valid_next;

  logic grant_if;
  logic grant_mem;
  logic force_if;
  logic resp_fire;

`ifdef MEM_PORT_ARB_STARVE_EN
  logic starve_clr;
  logic starve_inc;
  logic starve_at_max;

  // A loss is only counted when IF was actually waiting; any idle cycle
  // without an IF request, or an IF grant, restarts the count.
  assign starve_clr = (state_reg == IDLE) && (!if_valid || grant_if);
  assign starve_inc = grant_mem && if_valid;

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (starve_clr),
    .inc    (starve_inc),
    .at_max (starve_at_max)
  );

  assign force_if = starve_at_max && if_valid;
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = (STARVE_MAX == 0);
  assign force_if          = 1'b0;
`endif

  // Grants are only possible in IDLE; gating with rst keeps the ready
  // pulses low while reset is held even though the state already reads IDLE.
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (rst && (state_reg == IDLE)) begin
      if (mem_valid && !force_if) begin
        grant_mem = 1'b1;
      end else if (if_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  assign resp_fire = (state_reg == WAIT) && m_resp_valid;

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    drop_next      = drop_reg;
    addr_next      = addr_reg;
    we_next        = we_reg;
    wdata_next     = wdata_reg;
    req_valid_next = req_valid_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant_mem) begin
          owner_next     = OWN_MEM;
          addr_next      = mem_addr;
          we_next        = mem_we;
          wdata_next     = mem_wdata;
          drop_next      = 1'b0;
          req_valid_next = 1'b1;
          state_next     = REQ;
        end else if (grant_if) begin
          owner_next     = OWN_IF;
          addr_next      = if_addr;
          we_next        = 1'b0;
          wdata_next     = '0;
          drop_next      = 1'b0;
          req_valid_next = 1'b1;
          state_next     = REQ;
        end
      end
      REQ: begin
        if ((owner_reg == OWN_IF) && if_flush) begin
          drop_next = 1'b1;
        end
        if (m_req_ready) begin
          req_valid_next = 1'b0;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        if ((owner_reg == OWN_IF) && if_flush) begin
          drop_next = 1'b1;
        end
        if (m_resp_valid) begin
          drop_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next     = IDLE;
        req_valid_next = 1'b0;
        drop_next      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_IF;
      drop_reg      <= 1'b0;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      req_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      drop_reg      <= drop_next;
      addr_reg      <= addr_next;
      we_reg        <= we_next;
      wdata_reg     <= wdata_next;
      req_valid_reg <= req_valid_next;
    end
  end

  assign if_ready    = grant_if;
  assign mem_ready   = grant_mem;

  assign m_req_valid = req_valid_reg;
  assign m_addr      = addr_reg;
  assign m_we        = we_reg;
  assign m_wdata     = wdata_reg;

  // A flush arriving together with the response still swallows it, so the
  // live if_flush is folded in alongside the registered drop flag.
  assign mem_rvalid  = resp_fire && (owner_reg == OWN_MEM);
  assign if_rvalid   = resp_fire && (owner_reg == OWN_IF) && !drop_reg && !if_flush;

  assign mem_rdata   = mem_rvalid ? m_rdata : '0;
  assign if_rdata    = !if_rvalid ? 32'h0 :
                       (addr_reg[2] ? m_rdata[32 +: 32] : m_rdata[0 +: 32]);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a behavioural memory and a
//   response scoreboard. Expectation of starvation ordering depends on
//   MEM_PORT_ARB_STARVE_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [63:0] if_addr;
  logic        if_ready;
  logic        if_flush;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_valid;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        m_req_valid;
  logic        m_req_ready;
  logic [63:0] m_addr;
  logic        m_we;
  logic [63:0] m_wdata;
  logic        m_resp_valid;
  logic [63:0] m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_flush     (if_flush),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_addr       (m_addr),
    .m_we         (m_we),
    .m_wdata      (m_wdata),
    .m_resp_valid (m_resp_valid),
    .m_rdata      (m_rdata)
  );

  typedef struct {
    bit          is_if;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_cur;
  bit          order[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  logic [63:0] tb_mem [logic [63:0]];
  bit          ready_en = 1'b1;
  int          resp_delay = 0;
  logic [63:0] last_addr = '0;
  logic        last_we = 1'b0;
  logic [63:0] last_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input logic [63:0] a);
    logic [63:0] k;
    k = {a[63:3], 3'b000};
    if (tb_mem.exists(k)) return tb_mem[k];
    return {k[31:0] ^ 32'h5A5A_0000, ~k[31:0]};
  endfunction

  function automatic logic [63:0] exp_if(input logic [63:0] a);
    logic [63:0] w;
    w = exp_word(a);
    return {32'h0, (a[2] ? w[63:32] : w[31:0])};
  endfunction

  function automatic void sb_push(input bit is_if, input logic [63:0] d);
    exp_t e;
    e.is_if = is_if;
    e.data  = d;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: accepts when ready_en, answers resp_delay cycles after the handshake.
  initial begin : mem_model
    bit          hs;
    bit          pending;
    int          pend_cnt;
    logic [63:0] pend_data;
    logic [63:0] hs_addr;
    logic        hs_we;
    logic [63:0] hs_wdata;
    pending = 1'b0;
    pend_cnt = 0;
    pend_data = '0;
    m_req_ready = 1'b0;
    m_resp_valid = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      hs       = rst && m_req_valid && m_req_ready;
      hs_addr  = m_addr;
      hs_we    = m_we;
      hs_wdata = m_wdata;
      #1;
      m_resp_valid = 1'b0;
      m_rdata      = '0;
      if (hs) begin
        last_addr  = hs_addr;
        last_we    = hs_we;
        last_wdata = hs_wdata;
        if (hs_we) begin
          tb_mem[{hs_addr[63:3], 3'b000}] = hs_wdata;
          pend_data = '0;
        end else begin
          pend_data = exp_word(hs_addr);
        end
        pending  = 1'b1;
        pend_cnt = resp_delay;
      end
      if (pending) begin
        if (pend_cnt == 0) begin
          m_resp_valid = 1'b1;
          m_rdata      = pend_data;
          pending      = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      m_req_ready = ready_en;
    end
  end

  // Response monitor: every response must match the oldest expectation.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (if_rvalid || mem_rvalid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", {62'b0, if_rvalid, mem_rvalid}, 64'h0);
        end else begin
          mon_cur = sb.pop_front();
          check("resp_owner", {62'b0, if_rvalid, mem_rvalid}, mon_cur.is_if ? 64'h2 : 64'h1);
          check("resp_data", mon_cur.is_if ? {32'h0, if_rdata} : mem_rdata, mon_cur.data);
          $display("[%0d] response %s data=0x%h", cyc, mon_cur.is_if ? "IF" : "MEM", mon_cur.data);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // Drives pending IF/MEM requests until all are accepted. MEM issues n_mem
  // back-to-back requests at consecutive 8-byte addresses.
  task automatic run_reqs(input int n_mem, input int max_cyc, input bit push_if);
    int left;
    int n;
    bit ig;
    bit mg;
    left = n_mem;
    n = 0;
    mem_valid = (n_mem > 0);
    while ((if_valid || mem_valid) && n < max_cyc) begin
      @(negedge clk);
      n++;
      ig = if_ready;
      mg = mem_ready;
      if (ig) begin
        order.push_back(1'b1);
        if (push_if) sb_push(1'b1, exp_if(if_addr));
      end
      if (mg) begin
        order.push_back(1'b0);
        sb_push(1'b0, mem_we ? 64'h0 : exp_word(mem_addr));
      end
      tick();
      if (ig) if_valid = 1'b0;
      if (mg) begin
        left--;
        if (left == 0) mem_valid = 1'b0;
        else mem_addr = mem_addr + 64'h8;
      end
    end
    check("req_drained", {62'b0, if_valid, mem_valid}, 64'h0);
    if_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 64'h0);
  endtask

  initial begin : stim
    int   pos;
    int   exp_pos;
    logic seen;
    rst = 1'b0;
    if_valid = 1'b1;
    if_addr = 64'h0;
    if_flush = 1'b0;
    mem_valid = 1'b1;
    mem_addr = 64'h0;
    mem_we = 1'b0;
    mem_wdata = 64'h0;
    tb_mem[64'h100] = 64'hAAAA_BBBB_CCCC_DDDD;

    // Reset state, with both requesters asserting valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {62'b0, if_ready, mem_ready}, 64'h0);
    check("rst_rvalid", {62'b0, if_rvalid, mem_rvalid}, 64'h0);
    check("rst_mreq_we", {62'b0, m_req_valid, m_we}, 64'h0);
    check("rst_maddr", m_addr, 64'h0);
    check("rst_mwdata", m_wdata, 64'h0);
    check("rst_if_rdata", {32'h0, if_rdata}, 64'h0);
    check("rst_mem_rdata", mem_rdata, 64'h0);
    if_valid = 1'b0;
    mem_valid = 1'b0;
    tick();
    rst = 1'b1;

    // IF-only read of 0x104: grant N, request N+1, response N+2, next grant N+3
    tick();
    if_addr = 64'h104;
    if_valid = 1'b1;
    sb_push(1'b1, 64'hAAAABBBB);
    @(negedge clk);
    check("t1_if_ready", if_ready, 1'b1);
    check("t1_mreq_n", m_req_valid, 1'b0);
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    check("t1_mreq_n1", m_req_valid, 1'b1);
    check("t1_maddr", m_addr, 64'h104);
    check("t1_mwe", m_we, 1'b0);
    tick();
    mem_addr = 64'h208;
    mem_we = 1'b0;
    mem_valid = 1'b1;
    @(negedge clk);
    check("t1_if_rvalid_n2", if_rvalid, 1'b1);
    check("t1_no_grant_resp_cycle", mem_ready, 1'b0);
    @(negedge clk);
    check("t1_grant_n3", mem_ready, 1'b1);
    sb_push(1'b0, exp_word(64'h208));
    tick();
    mem_valid = 1'b0;
    drain(20);

    // Simultaneous IF (0x100) and MEM load (0x200): MEM first
    order.delete();
    tick();
    if_addr = 64'h100;
    if_valid = 1'b1;
    mem_addr = 64'h200;
    mem_we = 1'b0;
    run_reqs(1, 40, 1'b1);
    check("t2_grant_count", order.size(), 64'h2);
    check("t2_first_mem", {63'b0, order[0]}, 64'h0);
    check("t2_second_if", {63'b0, order[1]}, 64'h1);
    drain(20);

    // Store 0x40 <- 0x1234 with memory stalling the request for 3 cycles
    @(negedge clk);
    ready_en = 1'b0;
    tick();
    mem_addr = 64'h40;
    mem_we = 1'b1;
    mem_wdata = 64'h1234;
    mem_valid = 1'b1;
    @(negedge clk);
    check("t3_mem_ready", mem_ready, 1'b1);
    sb_push(1'b0, 64'h0);
    tick();
    mem_valid = 1'b0;
    mem_we = 1'b0;
    mem_wdata = 64'h0;
    repeat (3) begin
      @(negedge clk);
      check("t3_req_hold", {62'b0, m_req_valid, m_we}, 64'h3);
      check("t3_mwdata", m_wdata, 64'h1234);
      check("t3_maddr", m_addr, 64'h40);
    end
    ready_en = 1'b1;
    drain(20);
    check("t3_hs_we", last_we, 1'b1);
    check("t3_hs_wdata", last_wdata, 64'h1234);
    check("t3_hs_addr", last_addr, 64'h40);
    tick();
    mem_addr = 64'h40;
    mem_we = 1'b0;
    run_reqs(1, 20, 1'b0);
    drain(20);

    // Starvation: MEM requests continuously while IF waits
    order.delete();
    tick();
    if_addr = 64'h104;
    if_valid = 1'b1;
    mem_addr = 64'h300;
    mem_we = 1'b0;
    run_reqs(6, 200, 1'b1);
    pos = -1;
    foreach (order[i]) if (order[i] && pos < 0) pos = i;
`ifdef MEM_PORT_ARB_STARVE_EN
    exp_pos = 4;
`else
    exp_pos = 6;
`endif
    check("t4_if_grant_pos", pos, exp_pos);
    check("t4_grant_count", order.size(), 64'h7);
    drain(60);

    // Flush of an accepted IF: during WAIT (v=0) and together with the response (v=1)
    for (int v = 0; v < 2; v++) begin
      resp_delay = (v == 0) ? 2 : 0;
      tick();
      if_addr = 64'h100;
      if_valid = 1'b1;
      @(negedge clk);
      check("t5_if_ready", if_ready, 1'b1);
      tick();
      if_valid = 1'b0;
      @(negedge clk);
      seen = if_rvalid;
      tick();
      if_flush = 1'b1;
      @(negedge clk);
      seen = seen | if_rvalid;
      tick();
      if_flush = 1'b0;
      repeat (5) begin
        @(negedge clk);
        seen = seen | if_rvalid;
      end
      check("t5_response_dropped", seen, 1'b0);
    end
    resp_delay = 0;
    // Flush in IDLE (even in the grant cycle) has no effect
    tick();
    if_addr = 64'h108;
    if_valid = 1'b1;
    if_flush = 1'b1;
    sb_push(1'b1, exp_if(64'h108));
    @(negedge clk);
    check("t5_idle_flush_grant", if_ready, 1'b1);
    tick();
    if_valid = 1'b0;
    if_flush = 1'b0;
    drain(20);
    tick();
    mem_addr = 64'h218;
    mem_we = 1'b0;
    run_reqs(1, 20, 1'b0);
    drain(20);

    // Reset while WAITing; the late response must be ignored
    resp_delay = 4;
    tick();
    if_addr = 64'h10C;
    if_valid = 1'b1;
    @(negedge clk);
    check("t6_if_ready", if_ready, 1'b1);
    tick();
    if_valid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_ready", {62'b0, if_ready, mem_ready}, 64'h0);
    check("t6_rst_rvalid", {62'b0, if_rvalid, mem_rvalid}, 64'h0);
    check("t6_rst_mreq", {62'b0, m_req_valid, m_we}, 64'h0);
    check("t6_rst_maddr", m_addr, 64'h0);
    tick();
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | if_rvalid | mem_rvalid | m_req_valid;
    end
    check("t6_late_resp_ignored", seen, 1'b0);
    resp_delay = 0;
    tick();
    mem_addr = 64'h200;
    mem_we = 1'b0;
    mem_valid = 1'b1;
    @(negedge clk);
    check("t6_idle_after_reset", mem_ready, 1'b1);
    sb_push(1'b0, exp_word(64'h200));
    tick();
    mem_valid = 1'b0;
    drain(20);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
